// File: rtl/morse_pkg.sv
// ============================================================================
// morse_pkg : symbol codes, buffer geometry, player states and entry check
// Revision  : 1.0
// ============================================================================
`default_nettype none

package morse_pkg;

  localparam int SEQ_W   = 10;
  localparam int NUM_SEQ = 16;

  localparam logic [1:0] SYM_DOT  = 2'b00;
  localparam logic [1:0] SYM_DASH = 2'b01;
  localparam logic [1:0] SYM_END  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SCAN       = 3'd1,
    ST_SYM_ON     = 3'd2,
    ST_SYM_GAP    = 3'd3,
    ST_LETTER_GAP = 3'd4,
    ST_DONE       = 3'd5
  } state_e;

  // A letter is playable only if its first pair is a real symbol; the
  // reserved code 10 acts as a terminator, so it cannot open a letter.
  function automatic logic entry_valid(input logic [SEQ_W-1:0] entry);
    return (entry[SEQ_W-1 -: 2] == SYM_DOT) || (entry[SEQ_W-1 -: 2] == SYM_DASH);
  endfunction

endpackage

`default_nettype wire

// File: rtl/morse_unit_timer.sv
// ============================================================================
// morse_unit_timer : free-running UNIT_CYCLES prescaler with clear and tick
// Revision         : 1.0
// ============================================================================
`default_nettype none

module morse_unit_timer #(
  parameter int UNIT_CYCLES = 12_500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic unit_tick
);

  localparam int              CNT_W   = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(UNIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || (cnt_q == CNT_MAX)) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign unit_tick = (cnt_q == CNT_MAX);

endmodule

`default_nettype wire

// File: rtl/morse_sequence_player.sv
// ============================================================================
// morse_sequence_player : plays a 16-entry Morse buffer as on/off keying.
// Optional letter_valid/letter_code outputs: MORSE_PLAYER_LETTER_OUT_EN
// Revision              : 1.0
// ============================================================================
`default_nettype none

module morse_sequence_player
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES      = 12_500_000,
  parameter int DASH_UNITS       = 3,
  parameter int LETTER_GAP_UNITS = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [NUM_SEQ*SEQ_W-1:0] i_sequence,
  output logic                     tone,
  output logic                     busy,
  output logic                     done
`ifdef MORSE_PLAYER_LETTER_OUT_EN
  ,
  output logic                     letter_valid,
  output logic [SEQ_W-1:0]         letter_code
`endif
);

  localparam int IDX_W     = $clog2(NUM_SEQ);
  localparam int MAX_UNITS = (DASH_UNITS > LETTER_GAP_UNITS) ? DASH_UNITS : LETTER_GAP_UNITS;
  localparam int UCNT_W    = (MAX_UNITS > 1) ? $clog2(MAX_UNITS + 1) : 1;

  state_e                   state_q, state_d;
  logic [NUM_SEQ*SEQ_W-1:0] seq_q, seq_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [SEQ_W-1:0]         sym_q, sym_d;
  logic [2:0]               sym_idx_q, sym_idx_d;
  logic [UCNT_W-1:0]        unit_cnt_q, unit_cnt_d;
  logic [UCNT_W-1:0]        unit_target;
  logic [SEQ_W-1:0]         cur_entry;
  logic                     unit_tick, unit_done, valid_below, timer_clear;

  morse_unit_timer #(.UNIT_CYCLES(UNIT_CYCLES)) u_unit_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (timer_clear),
    .unit_tick (unit_tick)
  );

  assign cur_entry = seq_q[int'(idx_q)*SEQ_W +: SEQ_W];
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign tone      = (state_q == ST_SYM_ON);
  assign done      = (state_q == ST_DONE);

  // Only a playable letter further down the buffer earns a letter gap.
  always_comb begin
    valid_below = 1'b0;
    for (int k = 0; k < NUM_SEQ; k++) begin
      if ((k < int'(idx_q)) && entry_valid(seq_q[k*SEQ_W +: SEQ_W])) valid_below = 1'b1;
    end
  end

  always_comb begin
    unit_target = '0;
    if ((state_q == ST_SYM_ON) && (sym_q[SEQ_W-1 -: 2] == SYM_DASH))
      unit_target = UCNT_W'(DASH_UNITS - 1);
    else if (state_q == ST_LETTER_GAP)
      unit_target = UCNT_W'(LETTER_GAP_UNITS - 1);
  end

  assign unit_done = unit_tick && (unit_cnt_q == unit_target);

`ifdef MORSE_PLAYER_LETTER_OUT_EN
  logic             letter_valid_q, letter_valid_d;
  logic [SEQ_W-1:0] letter_code_q, letter_code_d;
`endif

  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    idx_d      = idx_q;
    sym_d      = sym_q;
    sym_idx_d  = sym_idx_q;
`ifdef MORSE_PLAYER_LETTER_OUT_EN
    letter_valid_d = 1'b0;
    letter_code_d  = letter_code_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          seq_d   = i_sequence;
          idx_d   = IDX_W'(NUM_SEQ - 1);
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (entry_valid(cur_entry)) begin
          sym_d     = cur_entry;
          sym_idx_d = 3'd0;
          state_d   = ST_SYM_ON;
`ifdef MORSE_PLAYER_LETTER_OUT_EN
          letter_valid_d = 1'b1;
          letter_code_d  = cur_entry;
`endif
        end else if (idx_q != '0) begin
          idx_d = idx_q - 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_SYM_ON: begin
        if (unit_done) begin
          // The symbol register shifts so the live pair always sits on top.
          if ((sym_idx_q < 3'd4) && !sym_q[SEQ_W-3]) begin
            sym_d     = sym_q << 2;
            sym_idx_d = sym_idx_q + 3'd1;
            state_d   = ST_SYM_GAP;
          end else if (valid_below) begin
            state_d = ST_LETTER_GAP;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SYM_GAP: begin
        if (unit_done) state_d = ST_SYM_ON;
      end
      ST_LETTER_GAP: begin
        if (unit_done) begin
          idx_d   = idx_q - 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort && busy) state_d = ST_IDLE;
  end

  // Every state change restarts unit timing so each timed phase starts clean.
  assign timer_clear = (state_d != state_q);

  always_comb begin
    unit_cnt_d = unit_cnt_q;
    if (timer_clear)    unit_cnt_d = '0;
    else if (unit_tick) unit_cnt_d = unit_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      seq_q      <= '0;
      idx_q      <= '0;
      sym_q      <= '0;
      sym_idx_q  <= '0;
      unit_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      idx_q      <= idx_d;
      sym_q      <= sym_d;
      sym_idx_q  <= sym_idx_d;
      unit_cnt_q <= unit_cnt_d;
    end
  end

`ifdef MORSE_PLAYER_LETTER_OUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      letter_valid_q <= 1'b0;
      letter_code_q  <= '1;
    end else begin
      letter_valid_q <= letter_valid_d;
      letter_code_q  <= letter_code_d;
    end
  end

  assign letter_valid = letter_valid_q;
  assign letter_code  = letter_code_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_morse_sequence_player.sv
// ============================================================================
// tb_morse_sequence_player : per-cycle trace check of the Morse player
// Revision                 : 1.0
// ============================================================================
`default_nettype none

module tb_morse_sequence_player;

  localparam int U   = 4;
  localparam int NE  = 16;
  localparam int EW  = 10;

  logic             clk = 1'b0;
  logic             reset, start, abort;
  logic [NE*EW-1:0] i_sequence;
  logic             tone, busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Expected {tone, busy, done} per cycle, starting the cycle after start.
  logic [2:0] model_q[$];
  logic [2:0] exp_q[$];
  logic [2:0] ex, act;
  string      tag;

  morse_sequence_player #(
    .UNIT_CYCLES      (U),
    .DASH_UNITS       (3),
    .LETTER_GAP_UNITS (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .i_sequence (i_sequence),
    .tone       (tone),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      ex  = exp_q.pop_front();
      act = {tone, busy, done};
      n_tests++;
      if (act !== ex) begin
        n_fail++;
        $display("FAIL %s cycle %0d: {tone,busy,done} got %b expected %b", tag, cyc, act, ex);
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Playback expressed directly in Morse timing: one cycle per entry
  // looked at, symbols in units, letter gaps only when a letter follows.
  task automatic build_model(input logic [NE*EW-1:0] s);
    logic [EW-1:0] e;
    logic [1:0]    sy;
    logic          more;
    model_q.delete();
    for (int k = NE - 1; k >= 0; k--) begin
      e = s[k*EW +: EW];
      model_q.push_back(3'b010);
      if (e[9]) continue;
      for (int p = 0; p < 5; p++) begin
        sy = e[9-2*p -: 2];
        if (sy[1]) break;
        if (p > 0) repeat (U) model_q.push_back(3'b010);
        repeat ((sy == 2'b01) ? 3*U : U) model_q.push_back(3'b110);
      end
      more = 1'b0;
      for (int j = k - 1; j >= 0; j--) if (s[j*EW + 9] == 1'b0) more = 1'b1;
      if (!more) break;
      repeat (3*U) model_q.push_back(3'b010);
    end
    model_q.push_back(3'b001);
  endtask

  // cut_at = m > 0: abort/reset sampled at edge N+m, so trace[m..] is idle.
  task automatic run(input string name, input logic [NE*EW-1:0] s, input int exp_len,
                     input int abort_at, input int reset_at, input int restart_at);
    int cut;
    int len;
    build_model(s);
    chk({name, " model length"}, model_q.size(), exp_len);
    cut = 0;
    if (abort_at > 0) cut = abort_at;
    if (reset_at > 0 && (cut == 0 || reset_at < cut)) cut = reset_at;
    if (cut > 0) for (int i = cut; i < model_q.size(); i++) model_q[i] = 3'b000;
    repeat (3) model_q.push_back(3'b000);
    len = model_q.size();
    tag = name;
    i_sequence = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    i_sequence = '0;
    for (int i = 0; i < len; i++) exp_q.push_back(model_q[i]);
    for (int m = 1; m <= len; m++) begin
      abort = (m == abort_at);
      reset = (m == reset_at);
      start = (m == restart_at);
      @(posedge clk);
      #1;
    end
    abort = 1'b0;
    reset = 1'b0;
    start = 1'b0;
    chk({name, " trace consumed"}, exp_q.size(), 0);
  endtask

  function automatic logic [NE*EW-1:0] buf1(input int k, input logic [EW-1:0] e);
    logic [NE*EW-1:0] b;
    b = '1;
    b[k*EW +: EW] = e;
    return b;
  endfunction

  logic [NE*EW-1:0] seq_a, seq_et, seq_inv, seq_e_skip_e, seq_five;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    i_sequence = '1;
    tag = "reset";
    repeat (3) @(posedge clk);
    #1;
    chk("reset tone", int'(tone), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    seq_a   = buf1(15, 10'b00_01_11_11_11);
    seq_et  = buf1(15, 10'b00_11_11_11_11);
    seq_et[14*EW +: EW] = 10'b01_11_11_11_11;
    seq_inv = buf1(15, 10'b10_00_00_00_00);
    seq_inv[14*EW +: EW] = 10'b00_10_00_00_00;
    seq_e_skip_e = buf1(15, 10'b00_11_11_11_11);
    seq_e_skip_e[13*EW +: EW] = 10'b00_11_11_11_11;
    seq_five = buf1(15, 10'b00_00_00_00_00);

    // Hand-derived anchor points of the model for "A".
    build_model(seq_a);
    chk("model A scan slot",  int'(model_q[0]),  3'b010);
    chk("model A first tone", int'(model_q[1]),  3'b110);
    chk("model A dot end",    int'(model_q[4]),  3'b110);
    chk("model A gap",        int'(model_q[5]),  3'b010);
    chk("model A dash start", int'(model_q[9]),  3'b110);
    chk("model A dash end",   int'(model_q[20]), 3'b110);
    chk("model A done",       int'(model_q[21]), 3'b001);

    run("A",            seq_a,        22, 0,  0,  0);
    run("empty",        '1,           17, 0,  0,  0);
    run("E T",          seq_et,       31, 0,  0,  8);
    run("abort dash",   seq_a,        22, 14, 0,  0);
    run("replay A",     seq_a,        22, 0,  0,  0);
    run("abort at end", seq_a,        22, 21, 0,  0);
    run("reset dot",    seq_a,        22, 0,  3,  0);
    run("after reset",  seq_a,        22, 0,  0,  0);
    run("invalid skip", seq_inv,       7, 0,  0,  0);
    run("E skip E",     seq_e_skip_e, 24, 0,  0,  0);
    run("five dots",    seq_five,     38, 0,  0,  0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
